// File: rtl/register_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_pipe: DEPTH-stage elastic valid/ready pipeline with flush/count |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module register_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] mv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

  // A stage moves when it is valid and some stage below it is empty or the
  // consumer takes the last word; built top-down so mv has no self-loop.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    mv       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      mv[k]    = v_q[k] & (out_ready | !all_full);
      all_full = all_full & v_q[k];
    end
  end

  assign in_ready  = !flush & (!v_q[0] | mv[0]);
  assign out_valid = v_q[DEPTH-1] & !flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;

    for (int k = 1; k < DEPTH; k++) begin
      if (mv[k-1]) begin
        d_d[k] = d_q[k-1];
        v_d[k] = 1'b1;
      end else if (mv[k]) begin
        v_d[k] = 1'b0;
      end
    end

    if (in_xfer) begin
      d_d[0] = in_data;
      v_d[0] = 1'b1;
    end else if (mv[0]) begin
      v_d[0] = 1'b0;
    end

    if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CW'(1);
    end

    // Flush drops valids only; data registers keep their contents.
    if (flush) begin
      v_d     = '0;
      d_d     = d_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_pipe: scoreboard bench for DEPTH=4/WIDTH=8 and DEPTH=1/W=1   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_register_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic       in_data1, out_data1;
  logic       count1;
  logic       flush1 = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0 [$];
  logic       q1 [$];

  always #5 clk = ~clk;

  register_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  register_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40; i++) begin
      if (count == 3'd0) break;
      step();
    end
    chk(name, 32'(count), 32'd0);
  endtask

  task automatic monitor0();
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        q0.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL d0_unexpected_out: got %0h, expected no word", out_data);
          end else begin
            chk("d0_order", 32'(out_data), 32'(q0.pop_front()));
          end
        end
        if (in_valid && in_ready) q0.push_back(in_data);
      end
    end
  endtask

  task automatic monitor1();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q1.delete();
      end else begin
        if (out_valid1 && out_ready1) begin
          if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL d1_unexpected_out: got %0h, expected no word", out_data1);
          end else begin
            chk("d1_order", 32'(out_data1), 32'(q1.pop_front()));
          end
        end
        if (in_valid1 && in_ready1) q1.push_back(in_data1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    logic        v_exp, exp_rdy, in_x, out_x;
    int          idx;

    fork
      monitor0();
      monitor1();
    join_none

    // Reset with traffic offered
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = 1'b0; out_ready1 = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming 01..10, latency 4, steady count 4
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    #1;
    chk("stream_first_ready", 32'(in_ready), 32'd1);
    step();
    for (int j = 1; j <= 15; j++) begin
      in_data = 8'(j + 1);
      step();
      if (j < 3) begin
        chk("stream_latency_early", 32'(out_valid), 32'd0);
      end else begin
        chk("stream_out_valid", 32'(out_valid), 32'd1);
        chk("stream_count", 32'(count), 32'd4);
      end
      if (j == 3) chk("stream_first_word", 32'(out_data), 32'h01);
    end
    in_valid = 1'b0;
    wait_empty("stream_drain");

    // Backpressure fill with 21..26
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h21 + 8'(i);
      #1;
      chk("bp_accept_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_data = 8'h25;
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_count", 32'(count), 32'd4);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'h21);
    step();
    step();
    chk("bp_stall_data", 32'(out_data), 32'h21);
    chk("bp_stall_count", 32'(count), 32'd4);
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_passthru_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_passthru_count", 32'(count), 32'd4);
    in_data = 8'h26;
    step();
    in_valid = 1'b0;
    wait_empty("bp_drain");

    // Simultaneous in/out while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h35 + 8'(i);
      #1;
      chk("full_sim_ready", 32'(in_ready), 32'd1);
      step();
      chk("full_sim_count", 32'(count), 32'd4);
    end
    in_valid = 1'b0;
    wait_empty("full_sim_drain");

    // Flush with 3 words held
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h41 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_post_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("flush_next_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("flush_5a_latency", 32'(out_valid), 32'(j == 3));
    end
    chk("flush_5a_data", 32'(out_data), 32'h5A);
    wait_empty("flush_drain");
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_empty_count", 32'(count), 32'd0);
    chk("flush_empty_ready", 32'(in_ready), 32'd1);

    // Mid-stream reset with 3 words in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h61 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("midrst_pre_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h00);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h70;
    step();
    in_valid = 1'b0;
    wait_empty("midrst_drain");

    // DEPTH=1, WIDTH=1 with alternating out_ready
    pat   = 16'hB38D;
    v_exp = 1'b0;
    idx   = 0;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      out_ready1 = c[0];
      in_valid1  = 1'b1;
      in_data1   = pat[idx];
      #1;
      exp_rdy = !v_exp | out_ready1;
      chk("d1_in_ready", 32'(in_ready1), 32'(exp_rdy));
      chk("d1_out_valid", 32'(out_valid1), 32'(v_exp));
      chk("d1_count", 32'(count1), 32'(v_exp));
      in_x  = in_valid1 & exp_rdy;
      out_x = v_exp & out_ready1;
      if (in_x) v_exp = 1'b1;
      else if (out_x) v_exp = 1'b0;
      if (in_x) idx++;
      step();
    end
    chk("d1_all_sent", 32'(idx), 32'd12);
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    step();
    step();
    chk("d1_drained", 32'(out_valid1), 32'd0);

    chk("d0_queue_empty", 32'(q0.size()), 32'd0);
    chk("d1_queue_empty", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
